// File: rtl/numpad_encoder.sv
// Decimal keypad front end: synchronises and debounces ten key lines, then
// priority-encodes the accepted pattern into registered BCD, valid, strobe and multi-key outputs.
module numpad_encoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enablen,
  input  logic [9:0] numpad,
  output logic [3:0] BCDout,
  output logic       validData,
  output logic       keyStrobe,
  output logic       multiKey
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  // Highest pressed key wins; 4'hF stands for "no key".
  function automatic logic [3:0] top_key(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = 0; i < 10; i++) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, v[i]};
    end
    return (n > 4'd1);
  endfunction

  logic [9:0]    sync_q [SYNC_STAGES];
  logic [9:0]    sync_vec_s;
  logic [9:0]    prev_q;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [9:0]    acc_q,    acc_d;
  logic [3:0]    bcd_q,    bcd_d;
  logic          valid_n_q, valid_n_d;
  logic          strobe_q, strobe_d;
  logic          multi_q,  multi_d;
  logic          accept_s;

  // Synchroniser chain bringing the raw key lines into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 10'd0;
      end
    end else begin
      sync_q[0] <= numpad;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_vec_s = sync_q[SYNC_STAGES-1];

  // Debounce counter, accepted pattern and registered encoder outputs next-state.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    accept_s  = 1'b0;
    bcd_d     = 4'hF;
    valid_n_d = 1'b1;
    multi_d   = 1'b0;
    strobe_d  = 1'b0;

    if (enablen) begin
      cnt_d = {CW{1'b0}};
      acc_d = 10'd0;
    end else if (sync_vec_s != prev_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs track the pattern being latched this edge so the output edge
    // coincides with acceptance rather than trailing it by a cycle.
    if (!enablen && (cnt_d == CNT_MAX)) begin
      accept_s = 1'b1;
      acc_d    = sync_vec_s;
    end else begin
      accept_s = 1'b0;
    end

    bcd_d     = top_key(acc_d);
    valid_n_d = (acc_d == 10'd0);
    multi_d   = more_than_one(acc_d);

    if (accept_s && (acc_d != 10'd0)) begin
      strobe_d = valid_n_q || (bcd_d != bcd_q);
    end else begin
      strobe_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= 10'd0;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= 10'd0;
      bcd_q     <= 4'hF;
      valid_n_q <= 1'b1;
      strobe_q  <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      prev_q    <= sync_vec_s;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      valid_n_q <= valid_n_d;
      strobe_q  <= strobe_d;
      multi_q   <= multi_d;
    end
  end

  assign BCDout    = bcd_q;
  assign validData = valid_n_q;
  assign keyStrobe = strobe_q;
  assign multiKey  = multi_q;

endmodule

// File: tb/tb_numpad_encoder.sv
// Self-checking bench for numpad_encoder: directed keypad scenarios followed by
// random key activity, all compared against a history-based reference model.
module tb_numpad_encoder;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       enablen;
  logic [9:0] numpad;
  logic [3:0] BCDout;
  logic       validData;
  logic       keyStrobe;
  logic       multiKey;

  numpad_encoder #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .enablen  (enablen),
    .numpad   (numpad),
    .BCDout   (BCDout),
    .validData(validData),
    .keyStrobe(keyStrobe),
    .multiKey (multiKey)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int nstrobe     = 0;

  // Input history indexed by rising-edge number; edges up to last_rst saw cleared flops.
  logic [9:0] np_h [MAXC];
  logic       en_h [MAXC];
  int         k        = 0;
  int         last_rst = 0;

  logic [3:0] m_bcd = 4'hF;
  logic       m_val = 1'b1;
  logic       m_stb = 1'b0;
  logic       m_mk  = 1'b0;

  function automatic logic [9:0] inp(input int j);
    return (j <= last_rst) ? 10'd0 : np_h[j];
  endfunction

  function automatic logic [3:0] top_key(input logic [9:0] p);
    return 4'($clog2(int'(p) + 1) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    last_rst = k;
    m_bcd = 4'hF;
    m_val = 1'b1;
    m_stb = 1'b0;
    m_mk  = 1'b0;
  endtask

  // One rising edge: log inputs, advance the model, then compare all outputs.
  task automatic tick();
    logic       ok;
    logic [9:0] p;
    logic [3:0] nb;
    @(posedge clk);
    k++;
    np_h[k] = numpad;
    en_h[k] = enablen;
    if (rst) begin
      model_reset();
    end else if (enablen) begin
      m_bcd = 4'hF; m_val = 1'b1; m_stb = 1'b0; m_mk = 1'b0;
    end else begin
      // Accept when the synchronised pattern has been unchanged and enabled for D edges.
      ok = 1'b1;
      for (int j = k - D + 1; j <= k; j++) begin
        if (j <= last_rst || en_h[j] || inp(j - S) != inp(j - S - 1)) ok = 1'b0;
      end
      m_stb = 1'b0;
      if (ok) begin
        p = inp(k - S);
        if (p == 10'd0) begin
          m_bcd = 4'hF; m_val = 1'b1; m_mk = 1'b0;
        end else begin
          nb    = top_key(p);
          m_stb = m_val || (nb != m_bcd);
          m_bcd = nb;
          m_val = 1'b0;
          m_mk  = ($countones(p) >= 2);
        end
      end
    end
    #1;
    if (keyStrobe === 1'b1) nstrobe++;
    check("bcd",    32'(BCDout),    32'(m_bcd));
    check("valid",  32'(validData), 32'(m_val));
    check("strobe", 32'(keyStrobe), 32'(m_stb));
    check("multi",  32'(multiKey),  32'(m_mk));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [9:0] np, input logic en);
    @(negedge clk);
    numpad  = np;
    enablen = en;
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_bcd",   32'(BCDout),    32'hF);
    check("rst_valid", 32'(validData), 32'd1);
    check("rst_multi", 32'(multiKey),  32'd0);
    check("rst_strb",  32'(keyStrobe), 32'd0);
    ticks(hold);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s0;
    logic [9:0] pat;
    rst = 1'b1; enablen = 1'b0; numpad = 10'd0;
    ticks(3);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    ticks(10);
    check("idle_bcd", 32'(BCDout), 32'hF);

    // Disabled with key 0 held.
    s0 = nstrobe;
    drive(10'b0000000001, 1'b1);
    ticks(20);
    check("dis_valid", 32'(validData), 32'd1);
    check("dis_strobes", 32'(nstrobe - s0), 32'd0);

    // Walk one-hot keys 0..9 with exact 7-edge latency.
    drive(10'd0, 1'b0);
    ticks(10);
    s0 = nstrobe;
    for (int i = 0; i < 10; i++) begin
      drive(10'(1 << i), 1'b0);
      ticks(6);
      check("walk_hold", 32'(BCDout), (i == 0) ? 32'hF : 32'(i - 1));
      tick();
      check("walk_bcd", 32'(BCDout), 32'(i));
      check("walk_valid", 32'(validData), 32'd0);
      ticks(3);
    end
    check("walk_strobes", 32'(nstrobe - s0), 32'd10);

    // Release of key 4.
    drive(10'b0000010000, 1'b0);
    ticks(10);
    s0 = nstrobe;
    drive(10'd0, 1'b0);
    ticks(6);
    check("rel_hold", 32'(validData), 32'd0);
    tick();
    check("rel_valid", 32'(validData), 32'd1);
    check("rel_bcd", 32'(BCDout), 32'hF);
    ticks(5);
    check("rel_strobes", 32'(nstrobe - s0), 32'd0);

    // Bouncing key 3, then held.
    s0 = nstrobe;
    for (int t = 0; t < 4; t++) begin
      drive((t % 2 == 0) ? 10'b0000001000 : 10'd0, 1'b0);
      ticks(2);
      check("bnc_invalid", 32'(validData), 32'd1);
    end
    drive(10'b0000001000, 1'b0);
    ticks(6);
    check("bnc_hold", 32'(validData), 32'd1);
    tick();
    check("bnc_bcd", 32'(BCDout), 32'd3);
    check("bnc_strobe", 32'(keyStrobe), 32'd1);
    ticks(8);
    check("bnc_strobes", 32'(nstrobe - s0), 32'd1);

    // Two keys, then reset mid-press.
    drive(10'b0010000100, 1'b0);
    ticks(7);
    check("mk_bcd", 32'(BCDout), 32'd7);
    check("mk_multi", 32'(multiKey), 32'd1);
    async_reset(2);
    ticks(12);
    check("mk_after_rst", 32'(BCDout), 32'd7);

    // Random key activity.
    for (int seg = 0; seg < 180; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pat = 10'd0;
        3, 4, 5: pat = 10'(1 << $urandom_range(0, 9));
        default: pat = 10'($urandom);
      endcase
      if ($urandom_range(0, 30) == 0) async_reset($urandom_range(0, 2));
      drive(pat, ($urandom_range(0, 12) == 0));
      ticks($urandom_range(1, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
